// File: rtl/led_uart_tx.sv
// led_uart_tx: captures each byte the CPU presents on its LED port (one byte per
// rising edge of the level-held lr strobe), buffers it in a small FIFO and
// serialises it as 8N1 UART on tx. There is no back-pressure: a byte that
// arrives while the FIFO is full is dropped and the sticky overflow flag is set.
//
// Handshake: the CPU side has no valid/ready pair. A byte is offered exactly on
// the cycle where lr is high and was low the cycle before; it is accepted if the
// FIFO has room or if the transmitter pops an entry in that same cycle.
module led_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 8,
   parameter int FIFO_AW      = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         leds,
   input  logic               lr,
   output logic               tx,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               overflow
);

   localparam int                BC_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0]  CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // Capture and FIFO storage
   logic                 r_lr_q;
   logic [7:0]           r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]   r_wr_ptr;
   logic [FIFO_AW-1:0]   r_rd_ptr;
   logic [FIFO_AW:0]     r_count;
   logic                 r_overflow;

   // Transmitter
   state_t               r_state;
   logic [BC_W-1:0]      r_bc;
   logic [2:0]           r_bi;
   logic [7:0]           r_shreg;
   logic                 r_tx;

   // Combinational signals
   logic                 w_push;
   logic                 w_push_ok;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_bc_end;
   state_t               w_state_nx;
   logic [BC_W-1:0]      w_bc_nx;
   logic [2:0]           w_bi_nx;
   logic [7:0]           w_shreg_nx;
   logic                 w_tx_nx;

   assign w_push    = lr & ~r_lr_q;
   assign w_full    = (r_count == CNT_FULL);
   assign w_empty   = (r_count == '0);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign w_push_ok = w_push & (~w_full | w_pop);
   assign w_bc_end  = (r_bc == BC_LAST);

   // Strobe edge detector, FIFO pointers, occupancy count and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lr_q     <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_lr_q <= lr;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
      end
   end

   // FIFO data array; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= leds;
   end

   // Transmitter next-state, pop request and next tx level from the current state
   always_comb begin
      w_state_nx = r_state;
      w_bc_nx    = r_bc;
      w_bi_nx    = r_bi;
      w_shreg_nx = r_shreg;
      w_pop      = 1'b0;
      w_tx_nx    = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_tx_nx = 1'b1;
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_shreg_nx = r_mem[r_rd_ptr];
               w_bc_nx    = '0;
               w_state_nx = S_START;
            end
         end
         S_START: begin
            w_tx_nx = 1'b0;
            if (w_bc_end) begin
               w_bc_nx    = '0;
               w_bi_nx    = 3'd0;
               w_state_nx = S_DATA;
            end else begin
               w_bc_nx = r_bc + 1'b1;
            end
         end
         S_DATA: begin
            w_tx_nx = r_shreg[0];
            if (w_bc_end) begin
               w_bc_nx    = '0;
               w_shreg_nx = {1'b0, r_shreg[7:1]};
               if (r_bi == 3'd7) begin
                  w_state_nx = S_STOP;
               end else begin
                  w_bi_nx = r_bi + 3'd1;
               end
            end else begin
               w_bc_nx = r_bc + 1'b1;
            end
         end
         S_STOP: begin
            w_tx_nx = 1'b1;
            if (w_bc_end) begin
               w_bc_nx = '0;
               // Chain straight into the next start bit when data is waiting.
               if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_shreg_nx = r_mem[r_rd_ptr];
                  w_state_nx = S_START;
               end else begin
                  w_state_nx = S_IDLE;
               end
            end else begin
               w_bc_nx = r_bc + 1'b1;
            end
         end
         default: begin
            w_tx_nx    = 1'b1;
            w_bc_nx    = '0;
            w_bi_nx    = 3'd0;
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // Transmitter state register; tx is registered so the line never glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_bc    <= '0;
         r_bi    <= 3'd0;
         r_shreg <= 8'd0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_bc    <= w_bc_nx;
         r_bi    <= w_bi_nx;
         r_shreg <= w_shreg_nx;
         r_tx    <= w_tx_nx;
      end
   end

   assign tx         = r_tx;
   assign busy       = (r_state != S_IDLE) | (r_count != '0);
   assign fifo_count = r_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_led_uart_tx.sv
// tb_led_uart_tx: directed tests for led_uart_tx with a background UART line
// decoder. Inputs are driven and outputs sampled on the falling clock edge.
module tb_led_uart_tx;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    leds = 8'd0;
   logic          lr = 1'b0;
   logic          tx;
   logic          busy;
   logic [AW:0]   fifo_count;
   logic          overflow;

   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;

   logic [7:0]    rx_q [$];
   int            rx_t_q [$];
   int            rx_bad = 0;

   led_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .FIFO_AW      (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .leds       (leds),
      .lr         (lr),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // line decoder: start found at first low sample, bits sampled mid-cell
   initial begin : rx_monitor
      logic [7:0] sh;
      logic       good;
      bit         ab;
      int         t0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0 || tx !== 1'b0) continue;
         t0   = cyc;
         sh   = 8'd0;
         good = 1'b1;
         ab   = 1'b0;
         for (int k = 1; k < 10 * CPB; k++) begin
            @(negedge clk);
            if (rst !== 1'b0) begin
               ab = 1'b1;
               break;
            end
            if (k == CPB / 2 && tx !== 1'b0) good = 1'b0;
            if (k >= CPB + CPB / 2 && k <= 8 * CPB + CPB / 2 && ((k - CPB / 2) % CPB) == 0)
               sh[(k - CPB - CPB / 2) / CPB] = tx;
            if (k == 9 * CPB + CPB / 2 && tx !== 1'b1) good = 1'b0;
         end
         if (!ab) begin
            rx_q.push_back(sh);
            rx_t_q.push_back(t0);
            if (!good) rx_bad++;
         end
      end
   end

   // watchdog
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      lr   = 1'b0;
      leds = 8'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      rx_t_q.delete();
      rx_bad = 0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      leds = b;
      lr   = 1'b1;
      @(negedge clk);
      lr = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n_cmp++;
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle cyc %0d: tx=%b busy=%b cnt=%0d ovf=%b, want 1 0 0 0",
                     i, tx, busy, fifo_count, overflow);
         end
      end
   endtask

   task automatic test_single();
      logic [7:0] b;
      logic       e;
      int         bad;
      b = 8'hA5;
      do_reset();
      leds = b;
      lr   = 1'b1;
      fork
         begin
            repeat (40) @(negedge clk);
            lr = 1'b0;
         end
      join_none
      @(negedge clk);
      n_cmp++;
      if (fifo_count !== 4'd1 || tx !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL single_k0: cnt=%0d tx=%b busy=%b, want 1 1 1", fifo_count, tx, busy);
      end
      @(negedge clk);
      n_cmp++;
      if (fifo_count !== 4'd0 || tx !== 1'b1) begin
         n_err++;
         $display("FAIL single_k1: cnt=%0d tx=%b, want 0 1", fifo_count, tx);
      end
      @(negedge clk);
      for (int j = 0; j < 10; j++) begin
         e   = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
         bad = 0;
         for (int c = 0; c < CPB; c++) begin
            if (tx !== e) bad++;
            @(negedge clk);
         end
         n_cmp++;
         if (bad != 0) begin
            n_err++;
            $display("FAIL single_bit%0d: %0d of %0d cycles wrong, want level %b", j, bad, CPB, e);
         end
      end
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
         @(negedge clk);
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL single_after: %0d idle cycles not tx=1/busy=0", bad);
      end
      n_cmp++;
      if (rx_q.size() != 1) begin
         n_err++;
         $display("FAIL single_frames: got %0d frames, want 1", rx_q.size());
      end else begin
         n_cmp++;
         if (rx_q[0] !== b || rx_bad != 0) begin
            n_err++;
            $display("FAIL single_data: got %h (bad=%0d), want %h", rx_q[0], rx_bad, b);
         end
      end
   endtask

   task automatic test_back_to_back();
      int peak;
      peak = 0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         leds = 8'(i + 1);
         lr   = 1'b1;
         @(negedge clk);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         lr = 1'b0;
         repeat (2) begin
            @(negedge clk);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
         end
      end
      n_cmp++;
      if (peak != 2) begin
         n_err++;
         $display("FAIL b2b_peak: got %0d, want 2", peak);
      end
      wait_rx(3, 4 * 10 * CPB);
      repeat (50) @(negedge clk);
      n_cmp++;
      if (rx_q.size() != 3) begin
         n_err++;
         $display("FAIL b2b_frames: got %0d, want 3", rx_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (rx_q[i] !== 8'(i + 1)) begin
               n_err++;
               $display("FAIL b2b_data%0d: got %h, want %h", i, rx_q[i], 8'(i + 1));
            end
         end
         for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (rx_t_q[i] - rx_t_q[i-1] != 10 * CPB) begin
               n_err++;
               $display("FAIL b2b_gap%0d: start spacing %0d, want %0d", i,
                        rx_t_q[i] - rx_t_q[i-1], 10 * CPB);
            end
         end
      end
      n_cmp++;
      if (busy !== 1'b0 || tx !== 1'b1 || rx_bad != 0) begin
         n_err++;
         $display("FAIL b2b_end: busy=%b tx=%b bad=%0d, want 0 1 0", busy, tx, rx_bad);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         push_byte(8'h10 + 8'(i));
         if (i == 8) begin
            n_cmp++;
            if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
               n_err++;
               $display("FAIL ovf_full: cnt=%0d ovf=%b, want 8 0", fifo_count, overflow);
            end
         end
      end
      n_cmp++;
      if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_drop: cnt=%0d ovf=%b, want 8 1", fifo_count, overflow);
      end
      wait_rx(9, 10 * 10 * CPB);
      repeat (200) @(negedge clk);
      n_cmp++;
      if (rx_q.size() != 9) begin
         n_err++;
         $display("FAIL ovf_frames: got %0d, want 9", rx_q.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (rx_q[i] !== 8'h10 + 8'(i)) begin
               n_err++;
               $display("FAIL ovf_data%0d: got %h, want %h", i, rx_q[i], 8'h10 + 8'(i));
            end
         end
      end
      n_cmp++;
      if (overflow !== 1'b1 || fifo_count !== 4'd0 || rx_bad != 0) begin
         n_err++;
         $display("FAIL ovf_sticky: ovf=%b cnt=%0d bad=%0d, want 1 0 0", overflow, fifo_count, rx_bad);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 9; i++) push_byte(8'h20 + 8'(i));
      repeat (142) @(negedge clk);
      n_cmp++;
      if (fifo_count !== 4'd8) begin
         n_err++;
         $display("FAIL fullpop_pre: cnt=%0d, want 8", fifo_count);
      end
      @(negedge clk);
      leds = 8'hEE;
      lr   = 1'b1;
      @(negedge clk);
      lr = 1'b0;
      n_cmp++;
      if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL fullpop_same: cnt=%0d ovf=%b, want 8 0", fifo_count, overflow);
      end
      wait_rx(10, 11 * 10 * CPB);
      repeat (50) @(negedge clk);
      n_cmp++;
      if (rx_q.size() != 10) begin
         n_err++;
         $display("FAIL fullpop_frames: got %0d, want 10", rx_q.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (rx_q[i] !== ((i == 9) ? 8'hEE : 8'h20 + 8'(i))) begin
               n_err++;
               $display("FAIL fullpop_data%0d: got %h, want %h", i, rx_q[i],
                        (i == 9) ? 8'hEE : 8'h20 + 8'(i));
            end
         end
      end
      n_cmp++;
      if (overflow !== 1'b0 || rx_bad != 0) begin
         n_err++;
         $display("FAIL fullpop_ovf: ovf=%b bad=%0d, want 0 0", overflow, rx_bad);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      push_byte(8'h0F);
      push_byte(8'h77);
      repeat (85) @(negedge clk);
      n_cmp++;
      if (tx !== 1'b0 || fifo_count !== 4'd1) begin
         n_err++;
         $display("FAIL midrst_pre: tx=%b cnt=%0d, want 0 1", tx, fifo_count);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (tx !== 1'b1 || fifo_count !== 4'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_abort: tx=%b cnt=%0d busy=%b, want 1 0 0", tx, fifo_count, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (rx_q.size() != 0) begin
         n_err++;
         $display("FAIL midrst_partial: got %0d frames, want 0", rx_q.size());
      end
      push_byte(8'h3C);
      wait_rx(1, 2 * 10 * CPB);
      repeat (200) @(negedge clk);
      n_cmp++;
      if (rx_q.size() != 1) begin
         n_err++;
         $display("FAIL midrst_frames: got %0d, want 1", rx_q.size());
      end else begin
         n_cmp++;
         if (rx_q[0] !== 8'h3C || rx_bad != 0 || tx !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_data: got %h bad=%0d tx=%b, want 3c 0 1", rx_q[0], rx_bad, tx);
         end
      end
   endtask

   task automatic test_lr_from_reset();
      @(negedge clk);
      rst  = 1'b1;
      leds = 8'h5A;
      lr   = 1'b1;
      repeat (2) @(negedge clk);
      rx_q.delete();
      rx_t_q.delete();
      rx_bad = 0;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (fifo_count !== 4'd1) begin
         n_err++;
         $display("FAIL lrrst_push: cnt=%0d, want 1", fifo_count);
      end
      wait_rx(1, 2 * 10 * CPB);
      repeat (200) @(negedge clk);
      n_cmp++;
      if (rx_q.size() != 1) begin
         n_err++;
         $display("FAIL lrrst_frames: got %0d, want 1", rx_q.size());
      end else begin
         n_cmp++;
         if (rx_q[0] !== 8'h5A || rx_bad != 0) begin
            n_err++;
            $display("FAIL lrrst_data: got %h bad=%0d, want 5a 0", rx_q[0], rx_bad);
         end
      end
      lr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_mid_reset();
      test_lr_from_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
